// File: rtl/spart_pkg.sv
// Shared constants and state types for the SPART serial port.
// Bus address map, FSM encodings, oversample timing and status bit indices.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int OSR      = 16;
  localparam int OSR_HALF = OSR / 2;

  localparam logic [3:0] TICK_LAST = 4'(OSR - 1);
  localparam logic [3:0] HALF_LAST = 4'(OSR_HALF - 1);

  localparam int STAT_RDA  = 0;
  localparam int STAT_TBR  = 1;
  localparam int STAT_FERR = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud tick generator for SPART.
// Down-counter reloads from the divisor; a DB high write reloads at once.
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET = 16'h00A2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_lo,
  input  logic       wr_hi,
  input  logic [7:0] data,
  output logic       tick
);

  logic [15:0] divisor;
  logic [15:0] cnt;

  // A count of 1 or 0 ends the period, so divisors 0 and 1 tick every cycle.
  assign tick = (cnt <= 16'd1);

  // Divisor registers and the reloading down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divisor <= DB_RESET;
      cnt     <= DB_RESET;
    end else begin
      if (wr_lo)
        divisor[7:0] <= data;
      if (wr_hi) begin
        divisor[15:8] <= data;
        cnt           <= {data, divisor[7:0]};
      end else if (tick) begin
        cnt <= divisor;
      end else begin
        cnt <= cnt - 16'd1;
      end
    end
  end

endmodule

// File: rtl/spart.sv
// SPART: bus-mapped 8N1 UART with 16x oversampling and programmable baud.
// Define SPART_FERR_EN to add a sticky framing-error status bit.
module spart
  import spart_pkg::*;
#(
  parameter logic [15:0] DB_RESET = 16'h00A2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rda,
  output logic       tbr,
  output logic       txd,
  input  logic       rxd
);

  logic       tick;
  logic       rd_en;
  logic       wr_en;
  logic       data_rd;
  logic       tx_go;
  logic       ferr;
  logic [7:0] status;
  logic [7:0] rd_data;

  tx_state_t  tx_state;
  logic [7:0] tx_shift;
  logic [3:0] tx_tick;
  logic [2:0] tx_bit;

  rx_state_t  rx_state;
  logic       rx_s1;
  logic       rx_s2;
  logic       rx_prev;
  logic       rx_fall;
  logic [7:0] rx_shift;
  logic [3:0] rx_tick;
  logic [2:0] rx_bit;
  logic       rx_done;
  logic       rx_good;
  logic [7:0] rx_buf;

  assign rd_en   = iocs & iorw;
  assign wr_en   = iocs & ~iorw;
  assign data_rd = rd_en & (ioaddr == ADDR_DATA);
  assign tx_go   = wr_en & (ioaddr == ADDR_DATA) & tbr;

  spart_baud_gen #(
    .DB_RESET(DB_RESET)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .wr_lo(wr_en & (ioaddr == ADDR_DBL)),
    .wr_hi(wr_en & (ioaddr == ADDR_DBH)),
    .data (databus),
    .tick (tick)
  );

  // Status word assembly.
  always_comb begin
    status            = 8'h00;
    status[STAT_RDA]  = rda;
    status[STAT_TBR]  = tbr;
    status[STAT_FERR] = ferr;
  end

  // Read mux; only data and status are ever driven onto the bus.
  always_comb begin
    rd_data = 8'h00;
    unique case (1'b1)
      (ioaddr == ADDR_DATA): rd_data = rx_buf;
      (ioaddr == ADDR_STAT): rd_data = status;
      default:               rd_data = 8'h00;
    endcase
  end

  assign databus = (rd_en & ~ioaddr[1]) ? rd_data : 8'hzz;

  // Transmit FSM: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= 8'h00;
      tx_tick  <= 4'd0;
      tx_bit   <= 3'd0;
      txd      <= 1'b1;
      tbr      <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_go) begin
            tx_shift <= databus;
            tx_tick  <= 4'd0;
            txd      <= 1'b0;
            tbr      <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tick) begin
            tx_tick <= tx_tick + 4'd1;
            if (tx_tick == TICK_LAST) begin
              txd      <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= 3'd0;
              tx_state <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (tick) begin
            tx_tick <= tx_tick + 4'd1;
            if (tx_tick == TICK_LAST) begin
              if (tx_bit == 3'd7) begin
                txd      <= 1'b1;
                tx_state <= TX_STOP;
              end else begin
                txd      <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 3'd1;
              end
            end
          end
        end
        TX_STOP: begin
          if (tick) begin
            tx_tick <= tx_tick + 4'd1;
            if (tx_tick == TICK_LAST) begin
              tbr      <= 1'b1;
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_done = (rx_state == RX_STOP) & tick & (rx_tick == TICK_LAST);
  assign rx_good = rx_done & rx_s2;

  // Receive FSM: mid-start glitch check, then mid-bit sampling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_shift <= 8'h00;
      rx_tick  <= 4'd0;
      rx_bit   <= 3'd0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_tick  <= 4'd0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (tick) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == HALF_LAST) begin
              if (rx_s2) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_tick  <= 4'd0;
                rx_bit   <= 3'd0;
                rx_state <= RX_DATA;
              end
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == TICK_LAST) begin
              rx_shift <= {rx_s2, rx_shift[7:1]};
              rx_bit   <= rx_bit + 3'd1;
              if (rx_bit == 3'd7)
                rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == TICK_LAST)
              rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Receive buffer and data-available flag; a new byte beats a data read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_buf <= 8'h00;
      rda    <= 1'b0;
    end else begin
      if (rx_good) begin
        rx_buf <= rx_shift;
        rda    <= 1'b1;
      end else if (data_rd) begin
        rda <= 1'b0;
      end
    end
  end

`ifdef SPART_FERR_EN
  logic stat_rd;
  logic rx_bad;

  assign stat_rd = rd_en & (ioaddr == ADDR_STAT);
  assign rx_bad  = rx_done & ~rx_s2;

  // Sticky framing error; a new error beats the clear-on-read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ferr <= 1'b0;
    else if (rx_bad)
      ferr <= 1'b1;
    else if (stat_rd)
      ferr <= 1'b0;
  end
`else
  assign ferr = 1'b0;
`endif

endmodule

// File: tb/tb_spart.sv
// Directed testbench for spart: bus decode, TX/RX framing, glitch, errors.
// Expected values are hand-derived for a divisor of 2 (32 clocks per bit).
module tb_spart;

  logic       clk;
  logic       rst;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rxd;
  logic       rda;
  logic       tbr;
  logic       txd;
  logic [7:0] dbus_drv;
  logic       dbus_en;
  wire  [7:0] databus;

  int checks;
  int errors;

  assign databus = dbus_en ? dbus_drv : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup p (databus[i]);
  end

  spart dut (
    .clk    (clk),
    .rst    (rst),
    .iocs   (iocs),
    .iorw   (iorw),
    .ioaddr (ioaddr),
    .databus(databus),
    .rda    (rda),
    .tbr    (tbr),
    .txd    (txd),
    .rxd    (rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    iocs     = 1'b1;
    iorw     = 1'b0;
    ioaddr   = a;
    dbus_drv = d;
    dbus_en  = 1'b1;
    @(negedge clk);
    iocs    = 1'b0;
    dbus_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    iocs   = 1'b1;
    iorw   = 1'b1;
    ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    iocs = 1'b0;
    iorw = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    @(negedge clk);
    rxd = 1'b0;
    repeat (32) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (32) @(negedge clk);
    end
    rxd = stopb;
    repeat (32) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Records txd each cycle until tbr returns, then decodes mid-bit samples.
  task automatic capture_tx(output logic [7:0] bits, output logic stopb,
                            output int len);
    logic tr [0:599];
    int   t;
    int   s;
    for (int i = 0; i < 600; i++) tr[i] = 1'b1;
    t = 0;
    while (t < 600) begin
      tr[t] = txd;
      if (tbr) break;
      t++;
      @(negedge clk);
    end
    len = t;
    s = -1;
    for (int i = 0; i < len; i++)
      if (tr[i] && s < 0) s = i;
    bits  = 8'h00;
    stopb = 1'b0;
    if (s >= 0 && s + 272 < 600) begin
      for (int i = 0; i < 8; i++) bits[i] = tr[s + 16 + 32 * i];
      stopb = tr[s + 272];
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || tbr !== 1'b1 || rda !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins txd=%b tbr=%b rda=%b want 1 1 0",
               txd, tbr, rda);
    end
    rst = 1'b1;
    bus_read(2'b01, v);
    checks++;
    if (v !== 8'h02) begin
      errors++;
      $display("FAIL reset_status got %h want 02", v);
    end
    bus_read(2'b00, v);
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reset_rxbuf got %h want 00", v);
    end
    bus_read(2'b10, v);
    checks++;
    if (v !== 8'hFF) begin
      errors++;
      $display("FAIL read_dbl_hiz got %h want FF (pulled)", v);
    end
    bus_read(2'b11, v);
    checks++;
    if (v !== 8'hFF) begin
      errors++;
      $display("FAIL read_dbh_hiz got %h want FF (pulled)", v);
    end
    bus_write(2'b01, 8'hFF);
    bus_read(2'b01, v);
    checks++;
    if (v !== 8'h02) begin
      errors++;
      $display("FAIL status_write_ignored got %h want 02", v);
    end
  endtask

  task automatic test_tx;
    logic [7:0] bits;
    logic       stopb;
    int         len;
    bit         quiet;
    bus_write(2'b10, 8'h02);
    bus_write(2'b11, 8'h00);
    bus_write(2'b00, 8'hA5);
    bus_write(2'b00, 8'hFF);
    checks++;
    if (tbr !== 1'b0 || txd !== 1'b0) begin
      errors++;
      $display("FAIL tx_start tbr=%b txd=%b want 0 0", tbr, txd);
    end
    capture_tx(bits, stopb, len);
    checks++;
    if (bits !== 8'hA5) begin
      errors++;
      $display("FAIL tx_data got %h want A5", bits);
    end
    checks++;
    if (stopb !== 1'b1) begin
      errors++;
      $display("FAIL tx_stop got %b want 1", stopb);
    end
    checks++;
    if (len < 316 || len > 321) begin
      errors++;
      $display("FAIL tx_busy_len got %0d want 316..321", len);
    end
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (txd !== 1'b1 || tbr !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL tx_second_write_ignored got %b want 1", quiet);
    end
  endtask

  task automatic test_rx;
    logic [7:0] v;
    send_frame(8'h3C, 1'b1);
    checks++;
    if (rda !== 1'b1) begin
      errors++;
      $display("FAIL rx_rda got %b want 1", rda);
    end
    bus_read(2'b01, v);
    checks++;
    if (v !== 8'h03) begin
      errors++;
      $display("FAIL rx_status got %h want 03", v);
    end
    bus_read(2'b00, v);
    checks++;
    if (v !== 8'h3C) begin
      errors++;
      $display("FAIL rx_data got %h want 3C", v);
    end
    checks++;
    if (rda !== 1'b0) begin
      errors++;
      $display("FAIL rx_rda_clear got %b want 0", rda);
    end
  endtask

  task automatic test_glitch;
    logic [7:0] v;
    @(negedge clk);
    rxd = 1'b0;
    repeat (10) @(negedge clk);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    checks++;
    if (rda !== 1'b0) begin
      errors++;
      $display("FAIL glitch_rda got %b want 0", rda);
    end
    send_frame(8'h81, 1'b1);
    checks++;
    if (rda !== 1'b1) begin
      errors++;
      $display("FAIL glitch_next_rda got %b want 1", rda);
    end
    bus_read(2'b00, v);
    checks++;
    if (v !== 8'h81) begin
      errors++;
      $display("FAIL glitch_next_data got %h want 81", v);
    end
  endtask

  task automatic test_ferr;
    logic [7:0] v;
    logic [7:0] exp1;
`ifdef SPART_FERR_EN
    exp1 = 8'h06;
`else
    exp1 = 8'h02;
`endif
    send_frame(8'h5A, 1'b0);
    repeat (40) @(negedge clk);
    checks++;
    if (rda !== 1'b0) begin
      errors++;
      $display("FAIL ferr_rda got %b want 0", rda);
    end
    bus_read(2'b01, v);
    checks++;
    if (v !== exp1) begin
      errors++;
      $display("FAIL ferr_status1 got %h want %h", v, exp1);
    end
    bus_read(2'b01, v);
    checks++;
    if (v !== 8'h02) begin
      errors++;
      $display("FAIL ferr_status2 got %h want 02", v);
    end
    bus_read(2'b00, v);
    checks++;
    if (v !== 8'h81) begin
      errors++;
      $display("FAIL ferr_buf_kept got %h want 81", v);
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [7:0] bits;
    logic       stopb;
    int         len;
    bus_write(2'b00, 8'hF7);
    repeat (143) @(negedge clk);
    checks++;
    if (txd !== 1'b0 || tbr !== 1'b0) begin
      errors++;
      $display("FAIL mid_tx_bit3 txd=%b tbr=%b want 0 0", txd, tbr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || tbr !== 1'b1) begin
      errors++;
      $display("FAIL async_reset txd=%b tbr=%b want 1 1", txd, tbr);
    end
    @(negedge clk);
    rst = 1'b1;
    bus_write(2'b10, 8'h02);
    bus_write(2'b11, 8'h00);
    bus_write(2'b00, 8'h55);
    capture_tx(bits, stopb, len);
    checks++;
    if (bits !== 8'h55 || stopb !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_tx got %h stop %b want 55 1", bits, stopb);
    end
    checks++;
    if (len < 317 || len > 322) begin
      errors++;
      $display("FAIL post_reset_len got %0d want 317..322", len);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    iocs     = 1'b0;
    iorw     = 1'b0;
    ioaddr   = 2'b00;
    rxd      = 1'b1;
    dbus_drv = 8'h00;
    dbus_en  = 1'b0;
    test_reset;
    test_tx;
    test_rx;
    test_glitch;
    test_ferr;
    test_reset_mid_tx;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spart.md
Name: spart

Overview:
- Peripheral-side responder for the processor-style I/O bus: address decode, read/write data, programmable baud, status flags.
- Serializes bytes onto txd and deserializes rxd into a receive buffer, as an 8N1 UART at 16x oversampling.
- Sits between the bus-master driver (ioaddr/iorw/iocs/databus, rda/tbr) and the board serial pins.

Parameters:
- DB_RESET, 16'h00A2, divisor loaded at reset (19200 baud x16 at 50 MHz).
- OSR, 16, oversample ticks per bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- iocs  in  1  chip select; all bus accesses ignored when low.
- iorw  in  1  1 = read, 0 = write.
- ioaddr  in  2  00 data, 01 status, 10 DB low, 11 DB high.
- databus  inout  8  shared bidirectional data bus.
- rda  out  1  receive data available.
- tbr  out  1  transmit buffer ready.
- txd  out  1  serial out, idle high.
- rxd  in  1  serial in, asynchronous to clk.

Behaviour:
- Reset values: txd=1, tbr=1, rda=0, rx buffer=0, divisor=DB_RESET, databus hi-z, baud counter loaded with divisor.
- Bus drive:
  - databus is driven only when iocs & iorw & ioaddr in {00,01}.
  - The drive is combinational, so the master captures in the same cycle.
  - Otherwise databus is 8'hzz. Reads of 10/11 are not driven.
- Read 00: returns the rx buffer. rda clears on the next edge.
- Read 01: returns {5'b0, ferr, tbr, rda}.
- Write 00 (iocs & !iorw) when tbr=1:
  - Latches databus into the tx shifter.
  - tbr=0 on the next edge.
  - Write 00 while tbr=0 is ignored.
- Write 10: updates divisor[7:0]. Write 11: updates divisor[15:8] and reloads the baud counter immediately.
- Write 01: ignored.
- Baud generator:
  - Down-counter, 1-cycle tick every divisor clocks, then reload.
  - Divisor 0 or 1 gives a tick every cycle.
  - A divisor change takes effect at the next reload, except that a DB high write reloads at once.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accepted write. txd=0 for OSR ticks.
  - DATA: 8 bits LSB first, OSR ticks each. Bit counter 0..7.
  - STOP: txd=1 for OSR ticks, then IDLE and tbr=1 on the same edge.
- RX path:
  - 2-flop synchronizer on rxd.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized falling edge.
  - At tick 8 of START: if rxd=1 (glitch), return to IDLE. Otherwise continue, sampling each data bit at mid-bit (every OSR ticks).
  - STOP sample = 1: load rx buffer, rda=1.
  - STOP sample = 0: framing error. Discard the byte, rda unchanged.
  - Return to IDLE after the stop sample (half stop bit).
- Simultaneous events:
  - Frame completion in the same cycle as a read of 00: new byte loaded, rda stays 1.
  - Overrun: a new byte while rda=1 overwrites the buffer silently.
- Reset mid-frame: both FSMs abort to IDLE. txd=1 immediately (async).
- The tick counter is 4 bits. It wraps 15 -> 0 at bit boundary.

Optional Feature:
- SPART_FERR_EN defined:
  - Sticky ferr register, set by a bad stop bit.
  - Cleared on the edge after a status read.
  - A set and a clear in the same cycle: set wins.
- SPART_FERR_EN undefined: status bit 2 tied 0. Framing errors are discarded silently.

Decomposition:
- spart_pkg:
  - ioaddr constants ADDR_DATA/ADDR_STAT/ADDR_DBL/ADDR_DBH.
  - tx_state_t and rx_state_t enums.
  - OSR_HALF constant.
  - Status bit index constants.
- Sub-module spart_baud_gen (divisor regs, down-counter, tick output, reload input). TX, RX and bus decode stay in spart.

Test Plan:
- Reset, then read 01 -> databus 8'h02 (tbr=1, rda=0). txd=1. Read 10 -> databus hi-z.
- Write DB low 8'h02, DB high 8'h00 -> ticks every 2 clk. Write 00 data 8'hA5 -> txd shows 0, 1,0,1,0,0,1,0,1, 1. Each bit lasts 32 clk. tbr=0 for 320 clk, then 1. A second write during the frame is ignored.
- DB=2, drive rxd frame 8'h3C -> rda=1 after the stop sample. Read 00 -> databus 8'h3C in the same cycle, rda=0 on the next edge.
- rxd low pulse of 5 ticks (glitch) -> no rda, RX returns to IDLE. Then a valid frame 8'h81 -> received correctly.
- Frame with stop=0 -> rda stays 0. With SPART_FERR_EN, status reads 8'h06, and the next status read returns 8'h02.
- Reset asserted mid-TX at data bit 3 -> txd=1, tbr=1 immediately. After release, a write of 8'h55 transmits a full clean frame.
